alu_frame_scheduler: RTL and testbench

//  Per-frame sequencer for the shared filter ALU. It sequences the ALU once for the

---
 rtl/alu_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_alu_frame_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_scheduler.sv
// Per-frame sequencer for the shared filter ALU: runs left then right channel,
// captures both accumulators and publishes the stereo pair with sleep/watchdog/overrun status.
module alu_frame_scheduler #(
  parameter int ACC_W      = 40,
  parameter int DATA_W     = 16,
  parameter int ZERO_LIMIT = 800,
  parameter int TIMEOUT    = 2048
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  output logic              alu_clear,
  output logic              alu_enable,
  output logic              alu_chan,
  input  logic              alu_done,
  input  logic [ACC_W-1:0]  alu_accum,
  output logic [ACC_W-1:0]  out_l,
  output logic [ACC_W-1:0]  out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sleep,
  output logic              overrun,
  output logic              timeout,
  input  logic              flags_clr
);

  localparam int ZC_W = $clog2(ZERO_LIMIT + 1);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CLR_L, RUN_L, CLR_R, RUN_R, PUBLISH} state_t;

  state_t          state_r;
  logic [ZC_W-1:0] zcnt_l_r, zcnt_r_r;
  logic [ZC_W-1:0] zcnt_l_nxt_s, zcnt_r_nxt_s;
  logic [WD_W-1:0] wd_r;
  logic            accept_s, overrun_set_s, timeout_set_s, wd_expired_s, both_sleep_s;

  // Handshake decode, saturating zero-run counters and watchdog expiry
  always_comb begin
    accept_s      = frame_valid & frame_ready;
    overrun_set_s = frame_valid & ~frame_ready;
    wd_expired_s  = (wd_r == WD_W'(TIMEOUT - 1));
    if (sample_l == {DATA_W{1'b0}}) begin
      zcnt_l_nxt_s = (zcnt_l_r == ZC_W'(ZERO_LIMIT)) ? zcnt_l_r : zcnt_l_r + ZC_W'(1);
    end else begin
      zcnt_l_nxt_s = {ZC_W{1'b0}};
    end
    if (sample_r == {DATA_W{1'b0}}) begin
      zcnt_r_nxt_s = (zcnt_r_r == ZC_W'(ZERO_LIMIT)) ? zcnt_r_r : zcnt_r_r + ZC_W'(1);
    end else begin
      zcnt_r_nxt_s = {ZC_W{1'b0}};
    end
    both_sleep_s = (zcnt_l_nxt_s == ZC_W'(ZERO_LIMIT)) && (zcnt_r_nxt_s == ZC_W'(ZERO_LIMIT));
    if ((state_r == RUN_L) || (state_r == RUN_R)) begin
      timeout_set_s = ~alu_done & wd_expired_s;
    end else begin
      timeout_set_s = 1'b0;
    end
  end

  // Frame sequencer with registered ALU controls, results and sticky flags
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r     <= IDLE;
      frame_ready <= 1'b1;
      alu_clear   <= 1'b1;
      alu_enable  <= 1'b0;
      alu_chan    <= 1'b0;
      out_l       <= {ACC_W{1'b0}};
      out_r       <= {ACC_W{1'b0}};
      out_valid   <= 1'b0;
      sleep       <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      zcnt_l_r    <= {ZC_W{1'b0}};
      zcnt_r_r    <= {ZC_W{1'b0}};
      wd_r        <= {WD_W{1'b0}};
    end else begin
      // A set event outranks a simultaneous clear
      if (overrun_set_s)  overrun <= 1'b1;
      else if (flags_clr) overrun <= 1'b0;
      if (timeout_set_s)  timeout <= 1'b1;
      else if (flags_clr) timeout <= 1'b0;

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            zcnt_l_r    <= zcnt_l_nxt_s;
            zcnt_r_r    <= zcnt_r_nxt_s;
            frame_ready <= 1'b0;
            if (both_sleep_s) begin
              sleep     <= 1'b1;
              out_l     <= {ACC_W{1'b0}};
              out_r     <= {ACC_W{1'b0}};
              out_valid <= 1'b1;
              state_r   <= PUBLISH;
            end else begin
              sleep     <= 1'b0;
              alu_clear <= 1'b1;
              alu_chan  <= 1'b0;
              state_r   <= CLR_L;
            end
          end
        end
        CLR_L, CLR_R: begin
          alu_clear  <= 1'b0;
          alu_enable <= 1'b1;
          wd_r       <= {WD_W{1'b0}};
          state_r    <= (state_r == CLR_L) ? RUN_L : RUN_R;
        end
        RUN_L: begin
          if (alu_done || wd_expired_s) begin
            out_l      <= alu_done ? alu_accum : {ACC_W{1'b0}};
            alu_enable <= 1'b0;
            alu_clear  <= 1'b1;
            alu_chan   <= 1'b1;
            state_r    <= CLR_R;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        RUN_R: begin
          if (alu_done || wd_expired_s) begin
            out_r      <= alu_done ? alu_accum : {ACC_W{1'b0}};
            alu_enable <= 1'b0;
            alu_clear  <= 1'b1;
            out_valid  <= 1'b1;
            state_r    <= PUBLISH;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        PUBLISH: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            frame_ready <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          frame_ready <= 1'b1;
          alu_clear   <= 1'b1;
          alu_enable  <= 1'b0;
          out_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_frame_scheduler.sv
// Directed self-checking bench for alu_frame_scheduler with a simple latency-programmable ALU model.
module tb_alu_frame_scheduler;

  logic        clk = 1'b0;
  logic        clear_n, frame_valid, frame_ready;
  logic [15:0] sample_l, sample_r;
  logic        alu_clear, alu_enable, alu_chan, alu_done;
  logic [39:0] alu_accum, out_l, out_r;
  logic        out_valid, out_ready, sleep, overrun, timeout, flags_clr;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          lat    = 10;
  logic        hang_left = 1'b0;
  logic [39:0] acc_l = 40'h00_1234_5678;
  logic [39:0] acc_r = 40'hFF_FFFF_0000;
  logic [7:0]  alu_cnt;
  int          en_rises = 0;
  int          both_cnt = 0;
  logic        prev_en = 1'b0;
  logic [1:0]  chan_seq = 2'b00;

  alu_frame_scheduler dut (
    .clk(clk), .clear_n(clear_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .sample_l(sample_l), .sample_r(sample_r), .alu_clear(alu_clear), .alu_enable(alu_enable),
    .alu_chan(alu_chan), .alu_done(alu_done), .alu_accum(alu_accum), .out_l(out_l),
    .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready), .sleep(sleep),
    .overrun(overrun), .timeout(timeout), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  // ALU model: done a programmable number of cycles after enable rises
  always @(posedge clk) begin
    if (!alu_enable) alu_cnt <= 8'd0;
    else if (alu_cnt != 8'hFF) alu_cnt <= alu_cnt + 8'd1;
  end
  assign alu_done  = alu_enable && (int'(alu_cnt) >= lat) && !(hang_left && !alu_chan);
  assign alu_accum = alu_chan ? acc_r : acc_l;

  // Enable-rise / channel log and clear-enable overlap monitor
  always @(negedge clk) begin
    prev_en <= alu_enable;
    if (alu_enable && !prev_en) begin
      en_rises <= en_rises + 1;
      chan_seq <= {chan_seq[0], alu_chan};
    end
    if (alu_enable && alu_clear) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    while (!frame_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("frame_ready_wait", 64'(frame_ready), 64'd1);
    frame_valid = 1'b1;
    sample_l    = l;
    sample_r    = r;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int n;
    int en0;
    logic seen;
    clear_n = 1'b0; frame_valid = 1'b0; sample_l = 16'h0000; sample_r = 16'h0000;
    out_ready = 1'b0; flags_clr = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_alu_clear", 64'(alu_clear), 64'd1);
    check("rst_alu_enable", 64'(alu_enable), 64'd0);
    check("rst_frame_ready", 64'(frame_ready), 64'd1);
    check("rst_outputs", {out_valid, sleep, overrun, timeout, alu_chan}, 64'd0);
    check("rst_out_l", 64'(out_l), 64'd0);
    clear_n = 1'b1;
    @(negedge clk);

    // Normal stereo frame with exact latency
    en0 = en_rises;
    send_frame(16'h0100, 16'hFF00);
    check("t1_busy", 64'(frame_ready), 64'd0);
    check("t1_clr_pulse", {alu_clear, alu_enable, alu_chan}, {61'd0, 3'b100});
    @(negedge clk);
    check("t1_enable", {alu_clear, alu_enable, alu_chan}, {61'd0, 3'b010});
    wait_valid("t1_valid", 100, n);
    check("t1_latency", 64'(n), 64'd23);
    check("t1_out_l", 64'(out_l), 64'h00_1234_5678);
    check("t1_out_r", 64'(out_r), 64'hFF_FFFF_0000);
    check("t1_sleep", 64'(sleep), 64'd0);
    check("t1_en_rises", 64'(en_rises - en0), 64'd2);
    check("t1_chan_seq", 64'(chan_seq), 64'b01);

    // Backpressure in PUBLISH with dropped frames
    for (int i = 0; i < 5; i++) begin
      frame_valid = (i % 2 == 0);
      @(negedge clk);
      check("t2_valid_hold", 64'(out_valid), 64'd1);
      check("t2_out_l_hold", 64'(out_l), 64'h00_1234_5678);
      check("t2_out_r_hold", 64'(out_r), 64'hFF_FFFF_0000);
      check("t2_not_ready", 64'(frame_ready), 64'd0);
    end
    frame_valid = 1'b0;
    check("t2_overrun", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_release", {out_valid, frame_ready}, 64'b01);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("t2_flags_clr", 64'(overrun), 64'd0);

    // Set and clear of overrun in the same cycle
    send_frame(16'h0001, 16'h0001);
    frame_valid = 1'b1;
    flags_clr   = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    flags_clr   = 1'b0;
    check("t6_set_wins", 64'(overrun), 64'd1);
    wait_valid("t6_valid", 100, n);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("t6_cleared", 64'(overrun), 64'd0);

    // Zero-input sleep after ZERO_LIMIT frames
    lat = 1;
    for (int i = 1; i < 800; i++) begin
      send_frame(16'h0000, 16'h0000);
      wait_valid("t3_zero_valid", 100, n);
    end
    check("t3_799_awake", 64'(sleep), 64'd0);
    check("t3_799_out_l", 64'(out_l), 64'h00_1234_5678);
    en0 = en_rises;
    send_frame(16'h0000, 16'h0000);
    check("t3_sleep_latency", 64'(out_valid), 64'd1);
    check("t3_sleep", 64'(sleep), 64'd1);
    check("t3_sleep_outs", 64'(out_l | out_r), 64'd0);
    repeat (3) @(negedge clk);
    check("t3_no_enable", 64'(en_rises - en0), 64'd0);
    en0 = en_rises;
    send_frame(16'h0001, 16'h0000);
    wait_valid("t3_wake_valid", 100, n);
    check("t3_wake_sleep", 64'(sleep), 64'd0);
    check("t3_wake_runs", 64'(en_rises - en0), 64'd2);
    check("t3_wake_out_r", 64'(out_r), 64'hFF_FFFF_0000);

    // Left channel watchdog expiry
    lat = 10;
    hang_left = 1'b1;
    send_frame(16'h0005, 16'h0006);
    wait_valid("t4_valid", 3000, n);
    hang_left = 1'b0;
    check("t4_latency", 64'(n), 64'd2061);
    check("t4_timeout", 64'(timeout), 64'd1);
    check("t4_out_l", 64'(out_l), 64'd0);
    check("t4_out_r", 64'(out_r), 64'hFF_FFFF_0000);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("t4_cleared", 64'(timeout), 64'd0);

    // Reset during RUN_R aborts the frame
    send_frame(16'h0007, 16'h0008);
    n = 0;
    while (!(alu_enable && alu_chan) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_run_r", {alu_enable, alu_chan}, 64'b11);
    clear_n = 1'b0;
    @(negedge clk);
    check("t5_reset_ctl", {alu_clear, alu_enable, out_valid, frame_ready, alu_chan}, 64'b10010);
    check("t5_reset_out_l", 64'(out_l), 64'd0);
    clear_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t5_no_publish", 64'(seen), 64'd0);
    check("no_clear_enable_overlap", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
